// File: rtl/crc_pkg.sv
// Shared definitions for the streaming CRC engine: FSM state encoding and
// default geometry.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WCODE  = 4;
  localparam int DEF_WPOLY  = 5;
  localparam int DEF_MAXLEN = 16;

endpackage

// File: rtl/crc_step.sv
// One-word CRC update, MSB first: a purely combinational chain of WCODE
// single-bit shift/feedback stages.
module crc_step #(
  parameter int WCODE = 4,
  parameter int WPOLY = 5
) (
  input  logic [WPOLY-2:0] crc,
  input  logic [WCODE-1:0] data,
  input  logic [WPOLY-1:0] poly,
  output logic [WPOLY-2:0] next_crc
);

  logic [WPOLY-2:0] c;
  logic [WPOLY-1:0] ext;

  // ext holds the shifted register with the feedback bit on top; xoring the
  // full polynomial clears that top bit through the leading 1.
  always_comb begin
    c   = crc;
    ext = '0;
    for (int i = WCODE - 1; i >= 0; i--) begin
      ext            = {c, 1'b0};
      ext[WPOLY-1]   = c[WPOLY-2] ^ data[i];
      if (ext[WPOLY-1]) begin
        ext = ext ^ poly;
      end
      c = ext[WPOLY-2:0];
    end
    next_crc = c;
  end

endmodule

// File: rtl/crc_stream.sv
// Framed streaming CRC engine: i_start opens a frame, one word per accepted
// beat, result held in DONE until the consumer acknowledges it.
module crc_stream
  import crc_pkg::*;
#(
  parameter int WCODE  = DEF_WCODE,
  parameter int WPOLY  = DEF_WPOLY,
  parameter int MAXLEN = DEF_MAXLEN,
  parameter int LW     = $clog2(MAXLEN + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WPOLY-1:0] i_poly,
  input  logic [WPOLY-2:0] i_init,
  input  logic             i_valid,
  input  logic [WCODE-1:0] i_data,
  input  logic             i_last,
  output logic             o_ready,
  input  logic             i_ack,
  output logic             o_valid,
  output logic [WPOLY-2:0] o_crc,
  output logic [LW-1:0]    o_len,
  output logic             o_err,
  output logic [1:0]       o_state
);

  // Handshake: a data beat transfers on an edge where i_valid && o_ready;
  // a result transfers on an edge where o_valid && i_ack. i_start overrides
  // both and restarts the frame.
  state_t           state;
  logic [WPOLY-2:0] crc;
  logic [WPOLY-1:0] poly;
  logic [LW-1:0]    len;
  logic             err;
  logic [WPOLY-2:0] crc_next;

  crc_step #(
    .WCODE(WCODE),
    .WPOLY(WPOLY)
  ) u_step (
    .crc     (crc),
    .data    (i_data),
    .poly    (poly),
    .next_crc(crc_next)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      crc   <= '0;
      poly  <= '0;
      len   <= '0;
      err   <= 1'b0;
    end else if (i_start) begin
      state <= BUSY;
      crc   <= i_init;
      poly  <= i_poly;
      len   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= IDLE;
        BUSY: begin
          if (i_valid) begin
            crc <= crc_next;
            len <= len + LW'(1);
            if (i_last) begin
              state <= DONE;
            end else if (len == LW'(MAXLEN - 1)) begin
              // Frame filled without a terminating word: flag truncation.
              err   <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (i_ack) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_ready = (state == BUSY);
  assign o_valid = (state == DONE);
  assign o_crc   = crc;
  assign o_len   = len;
  assign o_err   = err;
  assign o_state = state;

endmodule

// File: tb/tb_crc_stream.sv
// Directed self-checking bench for crc_stream with WCODE=4, WPOLY=5,
// polynomial 5'b10011 and hand-computed CRC values.
module tb_crc_stream;

  localparam int WCODE  = 4;
  localparam int WPOLY  = 5;
  localparam int MAXLEN = 16;
  localparam int LW     = 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic             i_clk;
  logic             i_rst;
  logic             i_start;
  logic [WPOLY-1:0] i_poly;
  logic [WPOLY-2:0] i_init;
  logic             i_valid;
  logic [WCODE-1:0] i_data;
  logic             i_last;
  logic             o_ready;
  logic             i_ack;
  logic             o_valid;
  logic [WPOLY-2:0] o_crc;
  logic [LW-1:0]    o_len;
  logic             o_err;
  logic [1:0]       o_state;

  int n_assert;
  int n_fail;

  crc_stream #(
    .WCODE (WCODE),
    .WPOLY (WPOLY),
    .MAXLEN(MAXLEN)
  ) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_start(i_start),
    .i_poly (i_poly),
    .i_init (i_init),
    .i_valid(i_valid),
    .i_data (i_data),
    .i_last (i_last),
    .o_ready(o_ready),
    .i_ack  (i_ack),
    .o_valid(o_valid),
    .o_crc  (o_crc),
    .o_len  (o_len),
    .o_err  (o_err),
    .o_state(o_state)
  );

  // Clock and reset
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic start_frame(input logic [3:0] init);
    i_start = 1'b1;
    i_init  = init;
    tick();
    i_start = 1'b0;
  endtask

  task automatic send(input logic [3:0] data, input logic last);
    i_valid = 1'b1;
    i_data  = data;
    i_last  = last;
    tick();
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic ack_result();
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    i_rst    = 1'b1;
    i_start  = 1'b0;
    i_poly   = 5'b10011;
    i_init   = '0;
    i_valid  = 1'b0;
    i_data   = '0;
    i_last   = 1'b0;
    i_ack    = 1'b0;

    #3;
    check("rst_state", 16'(o_state), 16'(S_IDLE));
    check("rst_ready", 16'(o_ready), 16'd0);
    check("rst_valid", 16'(o_valid), 16'd0);
    check("rst_crc",   16'(o_crc),   16'd0);
    check("rst_len",   16'(o_len),   16'd0);
    check("rst_err",   16'(o_err),   16'd0);
    tick();
    tick();
    i_rst = 1'b0;

    // Single word
    start_frame(4'b0000);
    check("t1_busy",  16'(o_state), 16'(S_BUSY));
    check("t1_ready", 16'(o_ready), 16'd1);
    send(4'b1101, 1'b1);
    check("t1_valid", 16'(o_valid), 16'd1);
    check("t1_ready_done", 16'(o_ready), 16'd0);
    check("t1_crc",   16'(o_crc),   16'b0100);
    check("t1_len",   16'(o_len),   16'd1);
    check("t1_err",   16'(o_err),   16'd0);
    ack_result();
    check("t1_idle",  16'(o_state), 16'(S_IDLE));
    // Data in IDLE is ignored
    send(4'b1111, 1'b1);
    check("idle_len", 16'(o_len), 16'd1);
    check("idle_crc", 16'(o_crc), 16'b0100);
    check("idle_state", 16'(o_state), 16'(S_IDLE));

    // Two words, with an ack in BUSY that must be ignored
    start_frame(4'b0000);
    send(4'b1101, 1'b0);
    ack_result();
    check("t2_ack_busy", 16'(o_state), 16'(S_BUSY));
    check("t2_len_mid",  16'(o_len),   16'd1);
    send(4'b0000, 1'b1);
    check("t2_crc", 16'(o_crc), 16'b1100);
    check("t2_len", 16'(o_len), 16'd2);
    // Backpressure: data held in DONE for three cycles
    i_valid = 1'b1;
    i_data  = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_crc",   16'(o_crc),   16'b1100);
      check("bp_len",   16'(o_len),   16'd2);
      check("bp_valid", 16'(o_valid), 16'd1);
    end
    i_valid = 1'b0;
    ack_result();
    check("bp_idle", 16'(o_state), 16'(S_IDLE));
    check("bp_valid_low", 16'(o_valid), 16'd0);

    // Chaining: init = CRC of first word
    start_frame(4'b0100);
    send(4'b0000, 1'b1);
    check("chain_crc", 16'(o_crc), 16'b1100);
    check("chain_len", 16'(o_len), 16'd1);
    ack_result();

    // Overflow at MAXLEN without last
    start_frame(4'b0000);
    for (int k = 0; k < MAXLEN - 1; k++) begin
      send(4'b0000, 1'b0);
    end
    check("ovf_busy15", 16'(o_state), 16'(S_BUSY));
    check("ovf_len15",  16'(o_len),   16'd15);
    send(4'b0000, 1'b0);
    check("ovf_valid", 16'(o_valid), 16'd1);
    check("ovf_err",   16'(o_err),   16'd1);
    check("ovf_len",   16'(o_len),   16'd16);
    check("ovf_crc",   16'(o_crc),   16'd0);
    ack_result();

    // Abort after two beats; start wins over a simultaneous beat
    start_frame(4'b0000);
    send(4'b1111, 1'b0);
    send(4'b1010, 1'b0);
    i_valid = 1'b1;
    i_data  = 4'b1111;
    start_frame(4'b0000);
    i_valid = 1'b0;
    check("abort_len0", 16'(o_len), 16'd0);
    check("abort_crc0", 16'(o_crc), 16'd0);
    send(4'b1101, 1'b1);
    check("abort_crc", 16'(o_crc), 16'b0100);
    check("abort_len", 16'(o_len), 16'd1);
    check("abort_err", 16'(o_err), 16'd0);

    // Start while in DONE reloads the frame
    start_frame(4'b1001);
    check("redo_busy", 16'(o_state), 16'(S_BUSY));
    check("redo_crc",  16'(o_crc),   16'b1001);

    // Asynchronous reset mid-BUSY
    send(4'b0110, 1'b0);
    send(4'b0011, 1'b0);
    #2;
    i_rst = 1'b1;
    #1;
    check("arst_state", 16'(o_state), 16'(S_IDLE));
    check("arst_ready", 16'(o_ready), 16'd0);
    check("arst_crc",   16'(o_crc),   16'd0);
    check("arst_len",   16'(o_len),   16'd0);
    check("arst_valid", 16'(o_valid), 16'd0);
    tick();
    i_rst = 1'b0;
    check("arst_idle", 16'(o_state), 16'(S_IDLE));
    start_frame(4'b0110);
    check("post_rst_busy", 16'(o_state), 16'(S_BUSY));
    check("post_rst_crc",  16'(o_crc),   16'b0110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/crc_stream.md
CRC_STREAM -- requirements
Module: crc_stream

Interface
REQ-001 Parameter WCODE, default 4: data word width in bits; the engine consumes one word per accepted beat.
REQ-002 Parameter WPOLY, default 5: generator polynomial width, including the implicit leading 1; the CRC width is WPOLY-1.
REQ-003 Parameter MAXLEN, default 16: maximum number of words per frame; the counter width is $clog2(MAXLEN+1).
REQ-004 Clocking: one clock; reset is asynchronous and active-high.
REQ-005 i_clk  in  1  clock; all state updates on the rising edge.
REQ-006 i_rst  in  1  asynchronous active-high reset.
REQ-007 i_start  in  1  one-cycle pulse; loads i_init and i_poly and opens a frame.
REQ-008 i_poly  in  WPOLY  generator polynomial, MSB = 1; sampled only on i_start.
REQ-009 i_init  in  WPOLY-1  initial CRC register value; sampled only on i_start.
REQ-010 i_valid  in  1  data word present.
REQ-011 i_data  in  WCODE  data word, processed MSB first.
REQ-012 i_last  in  1  qualifies the final word of the frame; meaningful only with i_valid.
REQ-013 o_ready  out  1  engine accepts a word this cycle.
REQ-014 i_ack  in  1  consumer takes the result.
REQ-015 o_valid  out  1  result available.
REQ-016 o_crc  out  WPOLY-1  running CRC register; final value while o_valid=1.
REQ-017 o_len  out  $clog2(MAXLEN+1)  number of words accepted in the current frame.
REQ-018 o_err  out  1  frame was truncated at MAXLEN without i_last; valid while o_valid=1.

Function
REQ-019 FSM states: IDLE, BUSY, DONE; the state after reset is IDLE.
REQ-020 IDLE: o_ready=0, o_valid=0; i_start moves to BUSY and loads the registers: crc<=i_init, poly<=i_poly[WPOLY-2:0], len<=0, err<=0.
REQ-021 BUSY: o_ready=1; a beat is accepted when i_valid=1 and o_ready=1.
REQ-022 Each accepted beat updates the CRC register in the same edge.
- Per data bit, MSB first: fb = crc[MSB] ^ bit.
- crc = {crc[WPOLY-3:0], 0}.
- If fb=1: crc ^= poly.
- len increments by 1.
- Throughput is one word per cycle; o_crc reflects the beat one cycle after acceptance.
REQ-023 An accepted beat with i_last=1 moves to DONE on the next edge.
REQ-024 An accepted beat without i_last that makes len reach MAXLEN sets err=1 and moves to DONE.
REQ-025 DONE: o_valid=1, o_ready=0; o_crc, o_len and o_err hold stable until i_ack=1, then the FSM moves to IDLE.
REQ-026 i_start in BUSY or DONE aborts the current frame and reloads the registers as in REQ-020; i_start has priority over i_valid and i_ack in the same cycle.
REQ-027 i_valid in IDLE or DONE is ignored; data and o_len are unchanged.
REQ-028 i_ack outside DONE is ignored.
REQ-029 A frame of zero words is impossible: the FSM leaves BUSY only via REQ-023, REQ-024 or REQ-026.
REQ-030 Chaining: the CRC of a frame A followed by B equals the CRC of frame B started with i_init set to the CRC of A.

Reset
REQ-031 While i_rst=1 (asynchronous), all outputs reset: state=IDLE, o_crc=0, o_len=0, o_err=0, o_valid=0, o_ready=0; stored poly=0.
REQ-032 Reset mid-frame discards all frame state; no result is presented afterwards.
REQ-033 The first i_start after reset deasserts is honoured in the cycle it occurs.

Structure
REQ-034 The shared package crc_pkg holds the FSM state enum (IDLE, BUSY, DONE) and default parameter constants.
REQ-035 One combinational sub-module, crc_step (parameters WCODE, WPOLY; ports crc, data, poly -> next crc), implements REQ-022; crc_stream instantiates it once.

Verification
All scenarios use WCODE=4, WPOLY=5, poly=5'b10011.
REQ-036 Single word: start with init=0, send data=4'b1101 with last -> o_valid=1, o_crc=4'b0100, o_len=1, o_err=0.
REQ-037 Two words: start with init=0, send 4'b1101 then 4'b0000+last -> o_crc=4'b1100, o_len=2; a frame started with init=4'b0100 and data 4'b0000+last also yields 4'b1100.
REQ-038 Backpressure: i_valid held high in DONE for 3 cycles before i_ack -> o_crc and o_len unchanged; back to IDLE one cycle after i_ack.
REQ-039 Overflow: MAXLEN=16, 16 beats with no last -> o_err=1, o_len=16, o_valid=1.
REQ-040 Abort: i_start after 2 beats, then 4'b1101+last with init=0 -> o_crc=4'b0100, o_len=1.
REQ-041 Reset: i_rst asserted mid-BUSY -> all outputs 0 in the same cycle, and IDLE after deassert.
